// File: rtl/tri_draw_sequencer_if.sv
// tri_draw_sequencer_if: host, vertex RAM, rasterizer and frame-buffer signals of the draw sequencer
interface tri_draw_sequencer_if #(
    parameter int COORD_W = 32,
    parameter int ADDR_W  = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
);
    logic                   start;
    logic [ADDR_W-1:0]      base_addr;
    logic [ADDR_W-1:0]      tri_count;
    logic                   proj_en;
    logic                   clear_en;
    logic [ADDR_W-1:0]      vert_addr;
    logic [9*COORD_W-1:0]   vert_data;
    logic [6*COORD_W-1:0]   rast_coords;
    logic                   rast_reset;
    logic                   rast_valid;
    logic [X_W-1:0]         rast_x;
    logic [Y_W-1:0]         rast_y;
    logic                   rast_finish;
    logic                   fb_we;
    logic [X_W+Y_W-1:0]     fb_addr;
    logic                   fb_data;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      tri_drawn;
    logic [ADDR_W-1:0]      tri_culled;

    modport master (
        input  start, base_addr, tri_count, proj_en, clear_en, vert_data,
               rast_valid, rast_x, rast_y, rast_finish,
        output vert_addr, rast_coords, rast_reset, fb_we, fb_addr, fb_data,
               busy, done, tri_drawn, tri_culled
    );

    modport slave (
        output start, base_addr, tri_count, proj_en, clear_en, vert_data,
               rast_valid, rast_x, rast_y, rast_finish,
        input  vert_addr, rast_coords, rast_reset, fb_we, fb_addr, fb_data,
               busy, done, tri_drawn, tri_culled
    );
endinterface

// File: rtl/tri_draw_sequencer.sv
// tri_draw_sequencer: walks the vertex RAM, launches the rasterizer per triangle and writes its pixels to the frame buffer
module tri_draw_sequencer #(
    parameter int COORD_W = 32,
    parameter int ADDR_W  = 8,
    parameter int STRIDE  = 9,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int PROJ_D  = 300
) (
    input logic clk,
    input logic reset,
    tri_draw_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_LATCH, S_LAUNCH, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t                 r_state, w_next;
    logic [ADDR_W-1:0]      r_addr, r_count, r_idx, r_drawn, r_culled, w_idx_inc;
    logic                   r_proj, r_first;
    logic [X_W-1:0]         r_cx;
    logic [Y_W-1:0]         r_cy;
    logic [6*COORD_W-1:0]   r_coords, w_coords;
    logic [2:0]             w_zpos;
    logic                   w_cull, w_last_y, w_clear_last, w_pix, w_finish;
    logic                   r_fb_we, r_fb_data;
    logic [X_W+Y_W-1:0]     r_fb_addr;

    // Per-vertex z>0 test; any non-positive z culls in projection mode
    for (genvar v = 0; v < 3; v++) begin : g_z
        assign w_zpos[v] = $signed(bus.vert_data[(3*v+2)*COORD_W +: COORD_W]) > 0;
    end

    // Coordinate j is x (even) or y (odd) of vertex j/2; divide by that vertex's z in projection mode
    for (genvar j = 0; j < 6; j++) begin : g_proj
        logic signed [COORD_W-1:0] w_v, w_z, w_q;
        assign w_v = bus.vert_data[(3*(j/2)+j%2)*COORD_W +: COORD_W];
        assign w_z = bus.vert_data[(3*(j/2)+2)*COORD_W +: COORD_W];
        assign w_q = COORD_W'(((2*COORD_W)'(w_v) * (2*COORD_W)'(PROJ_D)) / (2*COORD_W)'(w_z));
        assign w_coords[j*COORD_W +: COORD_W] = r_proj ? w_q : w_v;
    end

    assign w_cull       = r_proj && !(&w_zpos);
    assign w_idx_inc    = r_idx + ADDR_W'(1);
    assign w_last_y     = r_cy == Y_W'(V_RES - 1);
    assign w_clear_last = w_last_y && r_cx == X_W'(H_RES - 1);
    assign w_finish     = bus.rast_finish && !r_first;
    assign w_pix        = r_state == S_DRAW && bus.rast_valid &&
                          bus.rast_x < X_W'(H_RES) && bus.rast_y < Y_W'(V_RES);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = bus.clear_en ? S_CLEAR : (bus.tri_count == '0 ? S_DONE : S_FETCH);
            S_CLEAR:  if (w_clear_last) w_next = r_count == '0 ? S_DONE : S_FETCH;
            S_FETCH:  w_next = S_LATCH;
            S_LATCH:  w_next = w_cull ? S_NEXT : S_LAUNCH;
            S_LAUNCH: w_next = S_DRAW;
            S_DRAW:   if (w_finish) w_next = S_NEXT;
            S_NEXT:   w_next = w_idx_inc == r_count ? S_DONE : S_FETCH;
            S_DONE:   w_next = S_IDLE;
        endcase
    end

    // State-decoded control outputs
    always_comb begin
        bus.busy       = r_state != S_IDLE;
        bus.done       = r_state == S_DONE;
        bus.rast_reset = r_state == S_LAUNCH;
    end

    // Frame parameters, triangle walk, clear scan and status counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_drawn  <= '0;
            r_culled <= '0;
            r_proj   <= 1'b0;
            r_first  <= 1'b0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_coords <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_addr   <= bus.base_addr;
                r_count  <= bus.tri_count;
                r_proj   <= bus.proj_en;
                r_idx    <= '0;
                r_drawn  <= '0;
                r_culled <= '0;
                r_cx     <= '0;
                r_cy     <= '0;
            end
            if (r_state == S_CLEAR) begin
                r_cy <= w_last_y ? '0 : r_cy + Y_W'(1);
                if (w_last_y) r_cx <= r_cx + X_W'(1);
            end
            if (r_state == S_LATCH) begin
                r_coords <= w_coords;
                if (w_cull) r_culled <= r_culled + ADDR_W'(1);
            end
            if (r_state == S_DRAW && w_finish) r_drawn <= r_drawn + ADDR_W'(1);
            if (r_state == S_NEXT) begin
                r_idx  <= w_idx_inc;
                r_addr <= r_addr + ADDR_W'(STRIDE);
            end
            r_first <= r_state == S_LAUNCH;
        end
    end

    // Registered frame-buffer write port: clear writes 0, in-bounds rasterized pixels write 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= 1'b0;
        end else begin
            r_fb_we   <= r_state == S_CLEAR || w_pix;
            r_fb_addr <= r_state == S_CLEAR ? {r_cx, r_cy} : {bus.rast_x, bus.rast_y};
            r_fb_data <= w_pix;
        end
    end

    assign bus.vert_addr   = r_addr;
    assign bus.rast_coords = r_coords;
    assign bus.fb_we       = r_fb_we;
    assign bus.fb_addr     = r_fb_addr;
    assign bus.fb_data     = r_fb_data;
    assign bus.tri_drawn   = r_drawn;
    assign bus.tri_culled  = r_culled;
endmodule

// File: tb/tb_tri_draw_sequencer.sv
// tb_tri_draw_sequencer: table-driven frames plus reset, clear and guard sequences for the draw sequencer
module tb_tri_draw_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tri_draw_sequencer_if b();
    tri_draw_sequencer_if s();
    tri_draw_sequencer dut (.clk(clk), .reset(reset), .bus(b));
    tri_draw_sequencer #(.H_RES(4), .V_RES(3)) dut_s (.clk(clk), .reset(reset), .bus(s));

    typedef struct {
        logic [7:0]   base;
        logic [7:0]   count;
        logic         proj;
        logic         clip;
        logic         hold;
        logic         chk;
        logic [191:0] coords0;
        int           drawn;
        int           culled;
        int           resets;
        int           writes;
        int           busy;
        logic [7:0]   addr1;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [287:0] ram [256];
    logic [19:0]  wq[$];
    logic [19:0]  swq[$];
    logic [7:0]   aq[$];
    logic [191:0] cq[$];
    int dcnt = 0, bcnt = 0, sdcnt = 0, sbcnt = 0;
    int clx[3] = '{700, 100, 639};
    int cly[3] = '{10, 480, 479};
    vec_t vt[6];

    always @(posedge clk) b.vert_data <= ram[b.vert_addr];

    always @(negedge clk) begin
        if (b.fb_we) wq.push_back({b.fb_addr, b.fb_data});
        if (b.rast_reset) begin
            aq.push_back(b.vert_addr);
            cq.push_back(b.rast_coords);
        end
        if (b.done) dcnt++;
        if (b.busy) bcnt++;
        if (s.fb_we) swq.push_back({s.fb_addr, s.fb_data});
        if (s.done) sdcnt++;
        if (s.busy) sbcnt++;
    end

    function automatic logic [287:0] mk(input int x1, y1, z1, x2, y2, z2, x3, y3, z3);
        return {z3, y3, x3, z2, y2, x2, z1, y1, x1};
    endfunction

    function automatic logic [191:0] crd(input int x1, y1, x2, y2, x3, y3);
        return {y3, x3, y2, x2, y1, x1};
    endfunction

    task automatic chk(input string n, input logic [191:0] a, input logic [191:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int w0, a0, d0, b0, t, cyc;
        logic [19:0] exp_w[$];
        w0 = wq.size(); a0 = aq.size(); d0 = dcnt; b0 = bcnt; t = 0; cyc = 0;
        b.base_addr = v.base; b.tri_count = v.count; b.proj_en = v.proj; b.clear_en = 1'b0;
        b.rast_finish = v.hold;
        b.start = 1'b1;
        @(posedge clk); #1;
        b.start = 1'b0;
        while (dcnt == d0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (b.rast_reset) begin
                @(posedge clk); #1;
                for (int k = 0; k < 3; k++) begin
                    int x, y;
                    x = v.clip ? clx[k] : t * 10 + k + 1;
                    y = v.clip ? cly[k] : t + 2;
                    b.rast_valid = 1'b1;
                    b.rast_x = 10'(x);
                    b.rast_y = 9'(y);
                    b.rast_finish = (k == 2) || (k == 0 && v.hold);
                    if (x < 640 && y < 480) exp_w.push_back({10'(x), 9'(y), 1'b1});
                    @(posedge clk); #1;
                end
                b.rast_valid = 1'b0;
                b.rast_finish = v.hold;
                t++;
            end
        end
        chk({tag, " timeout"}, cyc < 500, 1);
        repeat (3) @(posedge clk);
        #1;
        b.rast_finish = 1'b0;
        chk({tag, " drawn"}, b.tri_drawn, v.drawn);
        chk({tag, " culled"}, b.tri_culled, v.culled);
        chk({tag, " resets"}, aq.size() - a0, v.resets);
        chk({tag, " writes"}, wq.size() - w0, v.writes);
        chk({tag, " done"}, dcnt - d0, 1);
        chk({tag, " busy"}, bcnt - b0, v.busy);
        if (v.resets > 0) chk({tag, " addr0"}, aq[a0], v.base);
        if (v.resets > 1) chk({tag, " addr1"}, aq[a0+1], v.addr1);
        if (v.chk) chk({tag, " coords"}, cq[a0], v.coords0);
        for (int i = 0; i < exp_w.size() && w0 + i < wq.size(); i++)
            chk({tag, " wr"}, wq[w0+i], exp_w[i]);
    endtask

    initial begin
        int cyc;
        vec_t rv;
        b.start = 0; b.base_addr = 0; b.tri_count = 0; b.proj_en = 0; b.clear_en = 0;
        b.rast_valid = 0; b.rast_x = 0; b.rast_y = 0; b.rast_finish = 0;
        s.start = 0; s.base_addr = 0; s.tri_count = 0; s.proj_en = 0; s.clear_en = 0;
        s.rast_valid = 0; s.rast_x = 0; s.rast_y = 0; s.rast_finish = 0; s.vert_data = '0;
        for (int i = 0; i < 256; i++) ram[i] = mk(1, 1, 1, 2, 2, 1, 3, 3, 1);
        ram[0]  = mk(1, 2, 99, 3, 4, -5, 5, 6, 0);
        ram[20] = mk(30, 60, 150, -30, 60, 150, 7, -7, 9);
        ram[29] = mk(1, 1, 5, 2, 2, 0, 3, 3, 5);
        vt[0] = '{8'd0,   8'd2, 1'b0, 1'b0, 1'b0, 1'b1, crd(1, 2, 3, 4, 5, 6), 2, 0, 2, 6, 15, 8'd9};
        vt[1] = '{8'd20,  8'd2, 1'b1, 1'b0, 1'b0, 1'b1, crd(60, 120, -60, 120, 233, -233), 1, 1, 1, 3, 11, 8'd0};
        vt[2] = '{8'd40,  8'd1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1, 0, 1, 1, 8, 8'd0};
        vt[3] = '{8'd50,  8'd2, 1'b0, 1'b0, 1'b1, 1'b0, '0, 2, 0, 2, 6, 15, 8'd59};
        vt[4] = '{8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 0, 0, 0, 1, 8'd0};
        vt[5] = '{8'd250, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2, 0, 2, 6, 15, 8'd3};

        #12;
        chk("rst busy", b.busy, 0);
        chk("rst done", b.done, 0);
        chk("rst fb_we", b.fb_we, 0);
        chk("rst rast_reset", b.rast_reset, 0);
        chk("rst vert_addr", b.vert_addr, 0);
        chk("rst tri_drawn", b.tri_drawn, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle busy", b.busy, 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        s.clear_en = 1'b1; s.start = 1'b1;
        @(posedge clk); #1;
        s.start = 1'b0;
        cyc = 0;
        while (sdcnt == 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("clear timeout", cyc < 100, 1);
        chk("clear writes", swq.size(), 12);
        chk("clear done", sdcnt, 1);
        chk("clear busy", sbcnt, 13);
        for (int i = 0; i < 12 && i < swq.size(); i++)
            chk($sformatf("clear wr%0d", i), swq[i], {10'(i / 3), 9'(i % 3), 1'b0});

        b.base_addr = 7; b.tri_count = 3; b.proj_en = 0; b.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre busy", b.busy, 1);
        chk("pre vaddr", b.vert_addr, 7);
        #2 reset = 1'b1;
        #1;
        chk("async busy", b.busy, 0);
        chk("async vaddr", b.vert_addr, 0);
        chk("async coords", b.rast_coords, 0);
        chk("async done", b.done, 0);
        chk("async fb_we", b.fb_we, 0);
        b.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post busy", b.busy, 0);

        b.base_addr = 60; b.tri_count = 1; b.start = 1'b1;
        @(posedge clk); #1;
        b.start = 1'b0;
        cyc = 0;
        while (!b.rast_reset && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid launch", cyc < 50, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            b.rast_valid = 1'b1; b.rast_x = 10'(200 + k); b.rast_y = 9'd100;
        end
        #2;
        chk("mid fb_we pre", b.fb_we, 1);
        reset = 1'b1;
        #1;
        chk("mid fb_we", b.fb_we, 0);
        chk("mid busy", b.busy, 0);
        chk("mid drawn", b.tri_drawn, 0);
        b.rast_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rv = '{8'd60, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1, 0, 1, 3, 8, 8'd0};
        run_vec(rv, "rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
